// File: rtl/serializer_pkg.sv
// Shared types and helpers for the variable-length frame serializer.
package serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // A length of 0, or anything beyond the frame capacity, means a full frame.
   function automatic int unsigned eff_len(input int unsigned len,
                                           input int unsigned n_samples);
      return ((len == 0) || (len > n_samples)) ? n_samples : len;
   endfunction

endpackage

// File: rtl/serializer_varlen_if.sv
// Parallel-frame receive side and serial-sample send side, both val/rdy.
interface serializer_varlen_if #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned N_SAMPLES = 8
);
   localparam int unsigned LW = $clog2(N_SAMPLES + 1);

   logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES];
   logic [LW-1:0]        recv_len;
   logic                 recv_rev;
   logic                 recv_val;
   logic                 recv_rdy;
   logic [BIT_WIDTH-1:0] send_msg;
   logic                 send_last;
   logic                 send_val;
   logic                 send_rdy;

   modport master (
      output recv_msg, recv_len, recv_rev, recv_val, send_rdy,
      input  recv_rdy, send_msg, send_last, send_val
   );

   modport slave (
      input  recv_msg, recv_len, recv_rev, recv_val, send_rdy,
      output recv_rdy, send_msg, send_last, send_val
   );
endinterface

// File: rtl/serializer_counter.sv
// Sample position counter with clear, enable and a terminal flag at len-1.
module serializer_counter #(
   parameter int unsigned LW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic [LW-1:0] len,
   output logic [LW-1:0] cnt,
   output logic          last_c
);

   // Clear wins over enable so a new frame always starts at sample 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + LW'(1);
      end
   end

   assign last_c = (cnt == (len - LW'(1)));

endmodule

// File: rtl/serializer_varlen.sv
// Serializes a parallel frame of up to N_SAMPLES words, forward or reversed.
module serializer_varlen
   import serializer_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned N_SAMPLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   serializer_varlen_if.slave bus
);

   localparam int unsigned LW = $clog2(N_SAMPLES + 1);
   localparam int unsigned IW = $clog2(N_SAMPLES);

   state_t               state_q, state_d;
   logic [BIT_WIDTH-1:0] sample_q [N_SAMPLES];
   logic [LW-1:0]        len_q;
   logic                 rev_q;
   logic [LW-1:0]        cnt;
   logic [LW-1:0]        idx;
   logic                 last_c;
   logic                 load;
   logic                 cnt_clr;
   logic                 cnt_en;
   logic                 recv_rdy_c;
   logic                 send_val_c;

   serializer_counter #(.LW(LW)) u_counter (
      .clk    (clk),
      .reset  (reset),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .len    (len_q),
      .cnt    (cnt),
      .last_c (last_c)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, handshake outputs and counter control.
   always_comb begin
      state_d    = state_q;
      recv_rdy_c = 1'b0;
      send_val_c = 1'b0;
      load       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      case (state_q)
         IDLE: begin
            recv_rdy_c = 1'b1;
            if (bus.recv_val) begin
               load    = 1'b1;
               cnt_clr = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            send_val_c = 1'b1;
            recv_rdy_c = bus.send_rdy & last_c;
            if (bus.send_rdy) begin
               if (last_c) begin
                  cnt_clr = 1'b1;
                  if (bus.recv_val) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame capture on a receive transfer; untouched otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(N_SAMPLES); i++) begin
            sample_q[i] <= '0;
         end
         len_q <= '0;
         rev_q <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < int'(N_SAMPLES); i++) begin
            sample_q[i] <= bus.recv_msg[i];
         end
         len_q <= LW'(eff_len(32'(bus.recv_len), N_SAMPLES));
         rev_q <= bus.recv_rev;
      end
   end

   assign idx = rev_q ? LW'(len_q - LW'(1) - cnt) : cnt;

   assign bus.recv_rdy  = recv_rdy_c;
   assign bus.send_val  = send_val_c;
   assign bus.send_last = (state_q == SEND) & last_c;
   assign bus.send_msg  = (state_q == SEND) ? sample_q[IW'(idx)] : '0;

endmodule

// File: doc/serializer_varlen.md
SERIALIZER_VARLEN -- requirements
Module: serializer_varlen

Interface
REQ-001 Parameter BIT_WIDTH, default 32, width in bits of one sample.
REQ-002 Parameter N_SAMPLES, default 8, maximum samples per frame; SHALL be >= 2.
REQ-003 Parameter LW, default $clog2(N_SAMPLES+1), width of the length field (derived, not overridden).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 recv_msg  in  BIT_WIDTH x N_SAMPLES  parallel frame, unpacked array, index 0..N_SAMPLES-1.
REQ-007 recv_len  in  LW  number of valid samples in frame.
REQ-008 recv_rev  in  1  order: 0 = index 0 first, 1 = index len-1 first.
REQ-009 recv_val  in  1  frame valid.
REQ-010 recv_rdy  out  1  block can accept a frame.
REQ-011 send_msg  out  BIT_WIDTH  current serial sample.
REQ-012 send_last  out  1  current sample is the final one of the frame.
REQ-013 send_val  out  1  send_msg valid.
REQ-014 send_rdy  in  1  downstream accepts.

Function
REQ-015 Handshakes SHALL be val/rdy: a transfer occurs in a cycle where val and rdy are both high.
REQ-016 FSM SHALL have two states, IDLE and SEND.
REQ-017 IDLE: recv_rdy = 1, send_val = 0, send_last = 0.
REQ-018 Recv transfer SHALL register all N_SAMPLES words, effective length and recv_rev, clear the sample counter, and enter SEND next cycle.
REQ-019 Effective length SHALL be recv_len, except 0 or values > N_SAMPLES map to N_SAMPLES.
REQ-020 SEND: send_val = 1; send_msg = buf[cnt] if rev = 0, buf[len-1-cnt] if rev = 1, from registers only.
REQ-021 send_last SHALL be high in SEND exactly when cnt = len-1.
REQ-022 A send transfer with send_last = 0 SHALL increment cnt; with send_val high and send_rdy low, send_msg, send_last and cnt SHALL hold.
REQ-023 A send transfer with send_last = 1 SHALL return to IDLE unless a recv transfer occurs in the same cycle.
REQ-024 In SEND, recv_rdy SHALL equal send_rdy AND send_last (combinational), allowing back-to-back frames with no bubble.
REQ-025 A simultaneous final send transfer and recv transfer SHALL load the new frame, clear cnt, and remain in SEND.
REQ-026 recv_msg, recv_len and recv_rev changes while no recv transfer occurs SHALL have no effect.
REQ-027 Latency: the first sample SHALL appear on send_msg one cycle after the recv transfer.
REQ-028 Throughput: a frame of length L with send_rdy held high SHALL occupy exactly L cycles in SEND.
REQ-029 cnt SHALL be LW bits wide and never exceed len-1.

Reset
REQ-030 While reset is high, the state SHALL be IDLE, and cnt, len, rev and all buffer words SHALL be 0, independent of clk.
REQ-031 After reset, outputs SHALL be recv_rdy = 1, send_val = 0, send_last = 0 and send_msg = 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; no sample of it SHALL be emitted after reset deasserts.

Structure
REQ-033 Package serializer_pkg SHALL hold the state enum typedef (IDLE, SEND) and a function computing the effective length.
REQ-034 The counter (clear, enable, terminal flag at len-1) SHALL be sub-module serializer_counter; the buffer and FSM SHALL stay in serializer_varlen.

Verification
REQ-035 Default params, frame {0..7} = 0x10..0x17, len = 8, rev = 0, send_rdy = 1 -> 0x10..0x17 on eight consecutive cycles, send_last only with 0x17.
REQ-036 len = 3, rev = 1, frame 0xA,0xB,0xC,... -> 0xC, 0xB, 0xA, with send_last on 0xA, then IDLE.
REQ-037 len = 0 and len = 15 -> 8 samples each; len = 1 -> a single sample with send_last = 1.
REQ-038 send_rdy toggled 1,0,0,1,... -> send_msg held stable while stalled, with no skipped or duplicated samples.
REQ-039 Two frames queued with recv_val held high and send_rdy = 1 -> 16 consecutive valid samples with no bubble; recv_rdy pulses only on each final sample.
REQ-040 Reset asserted at sample 4 of 8 -> next cycle recv_rdy = 1 and send_val = 0; a following frame is emitted from its first sample.
